// File: rtl/pong_pkg.sv
// Shared Pong definitions: rally FSM states and match-wide score limits.
// Used by the rally controller, the menu FSM and the score display.
package pong_pkg;

  localparam int MAX_SCORE = 9;
  localparam int SCORE_W   = 4;

  typedef enum logic [1:0] {
    ST_SERVE_WAIT,
    ST_PLAY,
    ST_HOLD,
    ST_OVER
  } rally_state_e;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rally_controller_frame_timer.sv
// Loadable frame down-counter; expire flags a tick arriving at count 1.
// The count parks at 1 so it never wraps while a timed state waits.
module frame_timer #(
  parameter int W       = 6,
  parameter int RST_VAL = 60
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         advance_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign expire_o = advance_i & (count_q == W'(1));

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (advance_i && (count_q > W'(1))) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= W'(RST_VAL);
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rally_controller.sv
// Rally sequencer for one Pong match: serve countdown, goal scoring,
// post-goal hold, serve direction and match-end detection.
module rally_controller #(
  parameter int MAX_SCORE   = pong_pkg::MAX_SCORE,
  parameter int SCORE_W     = pong_pkg::SCORE_W,
  parameter int SERVE_DELAY = 60,
  parameter int HOLD_FRAMES = 30
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_game,
  input  logic               frame_tick,
  input  logic               goal_left,
  input  logic               goal_right,
  output logic [SCORE_W-1:0] score_player_one,
  output logic [SCORE_W-1:0] score_player_two,
  output logic               ball_release,
  output logic               ball_center,
  output logic               serve_dir,
  output logic               match_over,
  output logic               winner
);

  import pong_pkg::*;

  localparam int TW =
    $clog2(max_int(SERVE_DELAY, HOLD_FRAMES) + 1);
  localparam logic [SCORE_W-1:0] MAX_S =
    SCORE_W'(MAX_SCORE);

  rally_state_e state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d;
  logic [SCORE_W-1:0] p2_q, p2_d;
  logic dir_q, dir_d;
  logic ctr_q, ctr_d;
  logic over_q, over_d;
  logic win_q, win_d;
  logic gl_q, gl_d;
  logic gr_q, gr_d;

  logic          ev_l;
  logic          ev_r;
  logic          timed;
  logic          advance;
  logic          expire;
  logic          load;
  logic [TW-1:0] load_val;

  frame_timer #(
    .W       (TW),
    .RST_VAL (SERVE_DELAY)
  ) u_timer (
    .clk_i      (clock),
    .rst_ni     (reset),
    .advance_i  (advance),
    .load_i     (load),
    .load_val_i (load_val),
    .expire_o   (expire)
  );

  assign ev_l    = enable_game & goal_left & ~gl_q;
  assign ev_r    = enable_game & goal_right & ~gr_q;
  assign timed   = (state_q == ST_SERVE_WAIT) |
                   (state_q == ST_HOLD);
  assign advance = frame_tick & enable_game & timed;

  always_comb begin
    state_d  = state_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    dir_d    = dir_q;
    ctr_d    = 1'b0;
    over_d   = over_q;
    win_d    = win_q;
    load     = 1'b0;
    load_val = TW'(SERVE_DELAY);
    // Edge history freezes with the game so a pause hides no edge.
    gl_d     = enable_game ? goal_left : gl_q;
    gr_d     = enable_game ? goal_right : gr_q;

    unique case (state_q)
      ST_SERVE_WAIT: begin
        if (expire) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (ev_l | ev_r) begin
          state_d  = ST_HOLD;
          load     = 1'b1;
          load_val = TW'(HOLD_FRAMES);
        end
        if (ev_l & ~ev_r) begin
          dir_d = 1'b0;
          if (p2_q != MAX_S) begin
            p2_d = p2_q + SCORE_W'(1);
          end
        end else if (ev_r & ~ev_l) begin
          dir_d = 1'b1;
          if (p1_q != MAX_S) begin
            p1_d = p1_q + SCORE_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (expire) begin
          if ((p1_q == MAX_S) || (p2_q == MAX_S)) begin
            state_d = ST_OVER;
            over_d  = 1'b1;
            win_d   = (p2_q == MAX_S);
          end else begin
            state_d = ST_SERVE_WAIT;
            load    = 1'b1;
            ctr_d   = 1'b1;
          end
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_SERVE_WAIT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_SERVE_WAIT;
      p1_q    <= '0;
      p2_q    <= '0;
      dir_q   <= 1'b0;
      ctr_q   <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
      gl_q    <= 1'b0;
      gr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      dir_q   <= dir_d;
      ctr_q   <= ctr_d;
      over_q  <= over_d;
      win_q   <= win_d;
      gl_q    <= gl_d;
      gr_q    <= gr_d;
    end
  end

  assign score_player_one = p1_q;
  assign score_player_two = p2_q;
  assign ball_release     = (state_q == ST_PLAY) & enable_game;
  assign ball_center      = ctr_q;
  assign serve_dir        = dir_q;
  assign match_over       = over_q;
  assign winner           = win_q;

endmodule
